// File: rtl/truth_table_sweeper.sv
// Sweeps all four {a,b} vectors into a 2-input gate, lets each settle, captures c
// into a 4-bit truth table and compares it with the reference latched at start.
module truth_table_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_bits,
    output logic       match
);

    // state    | meaning
    // S_IDLE   | waiting for start; table_bits/match hold last sweep result
    // S_SETTLE | vector idx driven on a/b, counting down settle time
    // S_SAMPLE | one cycle; c captured into table_bits[idx] at its closing edge
    // S_FINISH | one cycle; done pulses, match registered at its closing edge
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [1:0] idx_next;
    logic [3:0] settle_cnt;
    logic [3:0] expected_lat;

    assign idx_next = idx + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= 2'd0;
            settle_cnt   <= 4'd0;
            expected_lat <= 4'd0;
            a            <= 1'b0;
            b            <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_bits   <= 4'd0;
            match        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        table_bits   <= 4'd0;
                        match        <= 1'b0;
                        expected_lat <= expected;
                        idx          <= 2'd0;
                        settle_cnt   <= SETTLE_LOAD;
                        a            <= 1'b0;
                        b            <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    table_bits[idx] <= c;
                    if (idx == 2'd3) begin
                        a     <= 1'b0;
                        b     <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        idx        <= idx_next;
                        a          <= idx_next[1];
                        b          <= idx_next[0];
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end
                S_FINISH: begin
                    // table_bits already holds the last sample written when SAMPLE ended
                    match <= (table_bits == expected_lat);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven gate sweeps, randomized sweeps against
// a cycle-position reference model, plus reset-abort and result-hold sequences.
module tb_truth_table_sweeper;

    localparam int S     = 2;
    localparam int SWEEP = 4 * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] expected;
    logic       c;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [3:0] table_bits;
    logic       match;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] gate;
        logic [3:0] expv;
        logic [3:0] tbl;
        logic       mtch;
        bit         noisy;
        bit         extra;
        bit         hold;
        bit         scramble;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .expected   (expected),
        .c          (c),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .table_bits (table_bits),
        .match      (match)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Caller is at a negedge with the DUT idle. Returns at the negedge of the
    // IDLE cycle that follows FINISH.
    task automatic run_sweep(input string tag, input logic [3:0] gate, input logic [3:0] exp_in,
                             input logic [3:0] tbl_req, input logic match_req,
                             input bit noisy, input bit extra, input bit hold, input bit scramble);
        int         done_cnt;
        int         k;
        logic [1:0] idx;
        logic [3:0] mask;
        done_cnt = 0;
        start    = 1'b1;
        expected = exp_in;
        @(posedge clk);
        #1;
        if (!hold && !extra) start = 1'b0;
        if (scramble) expected = 4'($urandom);
        for (int j = 0; j <= SWEEP; j++) begin
            idx = 2'(j / (S + 1));
            if (j < SWEEP) begin
                if (!noisy || (j % (S + 1) == S)) c = gate[idx];
                else c = ~c;
            end
            @(negedge clk);
            if (extra) start = (j % 2 == 0);
            k    = j / (S + 1);
            mask = 4'((5'd1 << k) - 5'd1);
            chk($sformatf("%s c%0d busy", tag, j), busy, 1);
            chk($sformatf("%s c%0d done", tag, j), done, (j == SWEEP) ? 1 : 0);
            chk($sformatf("%s c%0d ab", tag, j), {a, b}, (j < SWEEP) ? idx : 2'd0);
            chk($sformatf("%s c%0d table", tag, j), table_bits, tbl_req & mask);
            chk($sformatf("%s c%0d match", tag, j), match, 0);
            if (done) done_cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        start = hold;
        chk($sformatf("%s idle busy", tag), busy, 0);
        chk($sformatf("%s idle done", tag), done, 0);
        chk($sformatf("%s idle ab", tag), {a, b}, 0);
        chk($sformatf("%s table", tag), table_bits, tbl_req);
        chk($sformatf("%s match", tag), match, match_req);
        chk($sformatf("%s done pulses", tag), done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] e;
        logic [3:0] last_tbl;
        logic       last_match;

        //            gate     expv     tbl      m     noisy extra hold scramble
        vecs[0] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
        vecs[1] = '{4'b0110, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // XOR vs wrong ref
        vecs[2] = '{4'b0111, 4'b0111, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // NAND, start held
        vecs[3] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // NOR back to back
        vecs[4] = '{4'b1110, 4'b1110, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // OR, extra starts
        vecs[5] = '{4'b0110, 4'b0110, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // XOR, noisy c
        vecs[6] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // expected changes late

        rst      = 1'b0;
        start    = 1'b0;
        expected = 4'd0;
        c        = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset a", a, 0);
        chk("reset b", b, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset table", table_bits, 0);
        chk("reset match", match, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i].gate, vecs[i].expv, vecs[i].tbl, vecs[i].mtch,
                      vecs[i].noisy, vecs[i].extra, vecs[i].hold, vecs[i].scramble);
        end

        // Abort an OR sweep while settling vector idx=2
        start    = 1'b1;
        expected = 4'b1110;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 2 * (S + 1); j++) begin
            c = (j / (S + 1)) != 0;
            @(posedge clk);
            #1;
        end
        c = 1'b1;
        #2;
        chk("abort pre busy", busy, 1);
        chk("abort pre ab", {a, b}, 2'b10);
        chk("abort pre table", table_bits, 4'b0010);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort ab", {a, b}, 0);
        chk("abort table", table_bits, 0);
        chk("abort match", match, 0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk($sformatf("abort hold%0d done", j), done, 0);
            chk($sformatf("abort hold%0d busy", j), busy, 0);
        end
        rst = 1'b0;
        run_sweep("post_abort", 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized sweeps: the captured table is the gate function, match compares
        // it with the reference present when start was accepted.
        for (int i = 0; i < 24; i++) begin
            g = 4'($urandom);
            e = ($urandom_range(0, 1) == 1) ? g : 4'($urandom);
            run_sweep($sformatf("rnd%0d", i), g, e, g, (g == e),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, 1'b1);
            last_tbl   = g;
            last_match = (g == e);
        end

        for (int j = 0; j < 4; j++) begin
            expected = 4'($urandom);
            c        = ~c;
            @(negedge clk);
            chk($sformatf("hold%0d table", j), table_bits, last_tbl);
            chk($sformatf("hold%0d match", j), match, last_match);
            chk($sformatf("hold%0d busy", j), busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
